// File: rtl/mem_access_ctrl_if.sv
// Request/response bus between a master and mem_access_ctrl.
// The master drives requests and consumes responses; the controller is the slave side.
interface mem_access_ctrl_if #(
  parameter int d_width   = 32,
  parameter int adr_width = 5
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [adr_width-1:0] req_adr;
  logic [d_width-1:0]   req_data;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [d_width-1:0]   rsp_data;

  modport master (
    output req_valid, req_we, req_adr, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_adr, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: turns a valid/ready request stream into dual-port memory cycles and returns read data.
// Optional macro MEM_INIT_EN: zero-fill sweep of every memory word after reset release.
module mem_access_ctrl #(
  parameter int d_width   = 32,
  parameter int adr_width = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_access_ctrl_if.slave     bus,
  output logic                 w_en_o,
  output logic [adr_width-1:0] adr_w_o,
  output logic [d_width-1:0]   data_w_o,
  output logic [adr_width-1:0] adr_r_o,
  input  logic [d_width-1:0]   data_r_i,
  output logic                 init_busy_o
);

  typedef enum logic [2:0] {
`ifdef MEM_INIT_EN
    INIT,
`endif
    IDLE,
    RD1,
    RD2,
    RSP
  } state_t;

`ifdef MEM_INIT_EN
  localparam int adr_max = 2 ** adr_width;
  localparam state_t RESET_STATE = INIT;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t               state_q, state_d;
  logic                 w_en_q, w_en_d;
  logic [adr_width-1:0] adr_w_q, adr_w_d;
  logic [d_width-1:0]   data_w_q, data_w_d;
  logic [adr_width-1:0] adr_r_q, adr_r_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [d_width-1:0]   rsp_data_q, rsp_data_d;
`ifdef MEM_INIT_EN
  logic [adr_width-1:0] init_cnt_q, init_cnt_d;
`endif

  // Gated by rst_n so nothing is accepted while reset is held.
  assign bus.req_ready = rst_n && (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign w_en_o        = w_en_q;
  assign adr_w_o       = adr_w_q;
  assign data_w_o      = data_w_q;
  assign adr_r_o       = adr_r_q;
`ifdef MEM_INIT_EN
  assign init_busy_o   = rst_n && (state_q == INIT);
`else
  assign init_busy_o   = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    w_en_d      = 1'b0;
    adr_w_d     = adr_w_q;
    data_w_d    = data_w_q;
    adr_r_d     = adr_r_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
`ifdef MEM_INIT_EN
    init_cnt_d  = init_cnt_q;
`endif
    case (state_q)
`ifdef MEM_INIT_EN
      INIT: begin
        w_en_d     = 1'b1;
        adr_w_d    = init_cnt_q;
        data_w_d   = '0;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == adr_width'(adr_max - 1)) begin
          state_d = IDLE;
        end
      end
`endif
      IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_we) begin
            w_en_d   = 1'b1;
            adr_w_d  = bus.req_adr;
            data_w_d = bus.req_data;
          end else begin
            adr_r_d = bus.req_adr;
            state_d = RD1;
          end
        end
      end
      RD1: state_d = RD2;
      // The memory registered data_r on the previous edge, so it is valid now.
      RD2: begin
        rsp_data_d  = data_r_i;
        rsp_valid_d = 1'b1;
        state_d     = RSP;
      end
      RSP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_STATE;
      w_en_q      <= 1'b0;
      adr_w_q     <= '0;
      data_w_q    <= '0;
      adr_r_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
`ifdef MEM_INIT_EN
      init_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      w_en_q      <= w_en_d;
      adr_w_q     <= adr_w_d;
      data_w_q    <= data_w_d;
      adr_r_q     <= adr_r_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
`ifdef MEM_INIT_EN
      init_cnt_q  <= init_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: behavioural 32x32 memory, scoreboard queue of expected read data,
// independent response monitor, plus directed checks of reset, latency, hold and busy behaviour.
module tb_mem_access_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        w_en;
  logic [4:0]  adr_w;
  logic [31:0] data_w;
  logic [4:0]  adr_r;
  logic [31:0] data_r;
  logic        init_busy;

  logic [31:0] mem [32];
  logic [31:0] expQ [$];
  int          total = 0;
  int          bad = 0;
  int          wenCount = 0;
  int          busyCount = 0;

  always #5 clk = ~clk;

  mem_access_ctrl_if #(.d_width(32), .adr_width(5)) bus ();

  mem_access_ctrl #(.d_width(32), .adr_width(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .w_en_o      (w_en),
    .adr_w_o     (adr_w),
    .data_w_o    (data_w),
    .adr_r_o     (adr_r),
    .data_r_i    (data_r),
    .init_busy_o (init_busy)
  );

  // Registered-read dual-port memory, both ports on clk.
  always @(posedge clk) begin
    if (w_en) mem[adr_w] <= data_w;
    data_r <= mem[adr_r];
  end

  always @(negedge clk) begin
    if (w_en) wenCount++;
    if (init_busy) busyCount++;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // A handshake seen at the negedge completes at the following posedge.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("rsp_unexpected", {31'b0, bus.rsp_valid}, 32'h0);
      end else begin
        e = expQ.pop_front();
        checkOutput("rsp_data", bus.rsp_data, e);
      end
    end
  end

  task automatic applyStimulus(input logic we, input logic [4:0] adr, input logic [31:0] data,
                               input logic [31:0] expData, output int waits);
    waits = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_adr   = adr;
    bus.req_data  = data;
    while (!bus.req_ready && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (!bus.req_ready) begin
      checkOutput("req_timeout", {31'b0, bus.req_ready}, 32'h1);
    end else begin
      if (!we) expQ.push_back(expData);
      @(posedge clk);
    end
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int k = 0;
    while (expQ.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    checkOutput("drain", 32'(expQ.size()), 32'h0);
  endtask

  task automatic waitInit();
    int k = 0;
    @(negedge clk);
    while (init_busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    checkOutput("init_done", {31'b0, init_busy}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 32; i++) mem[i] = 32'hDEAD_0000 | i;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_adr   = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_req_ready", {31'b0, bus.req_ready}, 32'h0);
    checkOutput("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
    checkOutput("rst_w_en", {31'b0, w_en}, 32'h0);
    checkOutput("rst_rsp_data", bus.rsp_data, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rel_rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
`ifdef MEM_INIT_EN
    checkOutput("rel_init_busy", {31'b0, init_busy}, 32'h1);
    checkOutput("rel_req_ready", {31'b0, bus.req_ready}, 32'h0);
    waitInit();
`else
    checkOutput("rel_w_en", {31'b0, w_en}, 32'h0);
    checkOutput("rel_req_ready", {31'b0, bus.req_ready}, 32'h1);
    checkOutput("rel_init_busy", {31'b0, init_busy}, 32'h0);
`endif

    // Write then read same address on consecutive cycles; latency and hold with rsp_ready=0.
    applyStimulus(1'b1, 5'h1A, 32'h0000_00C5, 32'h0, n);
    applyStimulus(1'b0, 5'h1A, 32'h0, 32'h0000_00C5, n);
    @(negedge clk);
    checkOutput("lat_edge1", {31'b0, bus.rsp_valid}, 32'h0);
    @(negedge clk);
    checkOutput("lat_edge2", {31'b0, bus.rsp_valid}, 32'h0);
    @(negedge clk);
    checkOutput("lat_edge3", {31'b0, bus.rsp_valid}, 32'h1);
    checkOutput("lat_data", bus.rsp_data, 32'h0000_00C5);
    checkOutput("busy_req_ready", {31'b0, bus.req_ready}, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("hold_valid", {31'b0, bus.rsp_valid}, 32'h1);
      checkOutput("hold_data", bus.rsp_data, 32'h0000_00C5);
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    waitDrain();
    @(negedge clk);
    checkOutput("rsp_drop", {31'b0, bus.rsp_valid}, 32'h0);

    // Back-to-back writes.
    n = wenCount;
    applyStimulus(1'b1, 5'h1B, 32'h0000_00D5, 32'h0, n);
    applyStimulus(1'b1, 5'h1C, 32'h0000_00E5, 32'h0, n);
    @(negedge clk);
    checkOutput("b2b_w_en", {31'b0, w_en}, 32'h1);
    checkOutput("b2b_adr_w", {27'b0, adr_w}, 32'h1C);
    checkOutput("b2b_data_w", data_w, 32'h0000_00E5);
    @(negedge clk);
    checkOutput("w_en_drop", {31'b0, w_en}, 32'h0);
    checkOutput("adr_w_hold", {27'b0, adr_w}, 32'h1C);

    // Second read issued while the first is in flight.
    applyStimulus(1'b0, 5'h1B, 32'h0, 32'h0000_00D5, n);
    @(negedge clk);
    checkOutput("rd1_req_ready", {31'b0, bus.req_ready}, 32'h0);
    applyStimulus(1'b0, 5'h1C, 32'h0, 32'h0000_00E5, n);
    checkOutput("busy_waits", n, 32'd2);
    waitDrain();

    // Address boundaries.
    applyStimulus(1'b1, 5'h00, 32'h1234_5678, 32'h0, n);
    applyStimulus(1'b1, 5'h1F, 32'hA5A5_A5A5, 32'h0, n);
    applyStimulus(1'b0, 5'h1F, 32'h0, 32'hA5A5_A5A5, n);
    applyStimulus(1'b0, 5'h00, 32'h0, 32'h1234_5678, n);
    waitDrain();

    // Reset while in RD2 drops the response.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_adr   = 5'h1B;
    checkOutput("pre_rst_ready", {31'b0, bus.req_ready}, 32'h1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rd2_rst_valid", {31'b0, bus.rsp_valid}, 32'h0);
    checkOutput("rd2_rst_ready", {31'b0, bus.req_ready}, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("rd2_rst_valid2", {31'b0, bus.rsp_valid}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_valid", {31'b0, bus.rsp_valid}, 32'h0);
`ifdef MEM_INIT_EN
    waitInit();
    applyStimulus(1'b0, 5'h1B, 32'h0, 32'h0, n);
`else
    checkOutput("post_rst_ready", {31'b0, bus.req_ready}, 32'h1);
    applyStimulus(1'b0, 5'h1B, 32'h0, 32'h0000_00D5, n);
`endif
    waitDrain();

`ifdef MEM_INIT_EN
    // Pre-load, reset, then count the init sweep and confirm zero-fill.
    applyStimulus(1'b1, 5'h00, 32'hFF, 32'h0, n);
    applyStimulus(1'b1, 5'h1F, 32'hFF, 32'h0, n);
    applyStimulus(1'b0, 5'h1F, 32'h0, 32'hFF, n);
    waitDrain();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n = busyCount;
    rst_n = 1'b1;
    waitInit();
    checkOutput("init_clks", busyCount - n, 32'd32);
    applyStimulus(1'b0, 5'h00, 32'h0, 32'h0, n);
    applyStimulus(1'b0, 5'h1F, 32'h0, 32'h0, n);
    waitDrain();
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
